// File: rtl/cle_pkg.sv
// Shared constants for the labeler reverse path: image geometry, FSM encodings
// and bitmap bit order.
package cle_pkg;

  localparam int IMG_DIM = 32;
  localparam int LBL_W   = 8;
  localparam int PIX_AW  = $clog2(IMG_DIM * IMG_DIM);
  localparam int BYTE_AW = PIX_AW - 3;

  // Label value that marks background pixels.
  localparam int BG_LABEL = 0;

  // Leftmost pixel of each group of eight lands in bit 7, matching the input ROM.
  localparam bit BM_MSB_FIRST = 1'b1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/cle_pack8.sv
// Packs a stream of single-bit pixels into bytes; ready pulses on the
// eighth bit of each group, with the completed byte on byte_o that cycle.
module cle_pack8
  import cle_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic       bit_i,
  output logic [7:0] byte_o,
  output logic       ready_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sr_q, sr_d;

  // The eighth bit bypasses the register so the byte is usable in the same cycle.
  assign byte_o  = BM_MSB_FIRST ? {sr_q, bit_i} : {bit_i, sr_q};
  assign ready_o = valid_i && (cnt_q == 3'd7);

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (valid_i) begin
      cnt_d = cnt_q + 3'd1;
      sr_d  = BM_MSB_FIRST ? {sr_q[5:0], bit_i} : {bit_i, sr_q[6:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/cle_label_packer.sv
// Scans the label SRAM, writes a packed 1-bit mask of one label to the bitmap
// memory and counts matches. CLE_PACKER_BBOX_EN adds bounding-box tracking.
//
// state    | meaning
// IDLE     | waiting for start
// READ     | issuing SRAM addresses 0..1023
// DRAIN    | last read data and last byte write in flight
// DONE     | results stable, finish high
module cle_label_packer #(
  parameter int IMG_DIM = cle_pkg::IMG_DIM,
  parameter int LBL_W   = cle_pkg::LBL_W
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic [LBL_W-1:0]                     label_sel_i,
  input  logic [LBL_W-1:0]                     sram_q_i,
  output logic [$clog2(IMG_DIM*IMG_DIM)-1:0]   sram_a_o,
  output logic                                 sram_wen_o,
  output logic [$clog2(IMG_DIM*IMG_DIM)-4:0]   bm_a_o,
  output logic [7:0]                           bm_d_o,
  output logic                                 bm_wen_o,
  output logic [$clog2(IMG_DIM*IMG_DIM):0]     match_cnt_o,
  output logic                                 busy_o,
  output logic                                 finish_o,
  output logic [$clog2(IMG_DIM)-1:0]           bbox_xmin_o,
  output logic [$clog2(IMG_DIM)-1:0]           bbox_xmax_o,
  output logic [$clog2(IMG_DIM)-1:0]           bbox_ymin_o,
  output logic [$clog2(IMG_DIM)-1:0]           bbox_ymax_o
);

  import cle_pkg::*;

  localparam int AW = $clog2(IMG_DIM * IMG_DIM);
  localparam int CW = $clog2(IMG_DIM);
  localparam int BW = AW - 3;

  state_t           state_q, state_d;
  logic [AW-1:0]    sram_a_q, sram_a_d;
  logic [LBL_W-1:0] label_q, label_d;
  logic             valid_q, valid_d;
  logic [AW-1:0]    pix_q, pix_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [BW-1:0]    bm_a_q, bm_a_d;
  logic [7:0]       bm_d_q, bm_d_d;
  logic             bm_wen_q, bm_wen_d;

  logic             start_ok;
  logic             match;
  logic [7:0]       pk_byte;
  logic             pk_ready;

  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign match    = valid_q && (sram_q_i == label_q);

  cle_pack8 u_pack8 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (start_ok),
    .valid_i (valid_q),
    .bit_i   (match),
    .byte_o  (pk_byte),
    .ready_o (pk_ready)
  );

  always_comb begin
    state_d  = state_q;
    sram_a_d = sram_a_q;
    label_d  = label_q;
    pix_d    = pix_q;
    cnt_d    = cnt_q;
    bm_a_d   = bm_a_q;
    bm_d_d   = bm_d_q;
    bm_wen_d = 1'b1;
    // Read data trails the address by one cycle.
    valid_d  = (state_q == ST_READ);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d  = ST_READ;
          label_d  = label_sel_i;
          sram_a_d = '0;
          pix_d    = '0;
          cnt_d    = '0;
        end
      end
      ST_READ: begin
        if (sram_a_q == '1) begin
          state_d = ST_DRAIN;
        end else begin
          sram_a_d = sram_a_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Leave once the final byte write is on the bus.
        if (!bm_wen_q && (bm_a_q == '1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_q) begin
      pix_d = pix_q + 1'b1;
      cnt_d = cnt_q + {{AW{1'b0}}, match};
    end

    if (pk_ready) begin
      bm_a_d   = pix_q[AW-1:3];
      bm_d_d   = pk_byte;
      bm_wen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      sram_a_q <= '0;
      label_q  <= LBL_W'(BG_LABEL);
      valid_q  <= 1'b0;
      pix_q    <= '0;
      cnt_q    <= '0;
      bm_a_q   <= '0;
      bm_d_q   <= '0;
      bm_wen_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sram_a_q <= sram_a_d;
      label_q  <= label_d;
      valid_q  <= valid_d;
      pix_q    <= pix_d;
      cnt_q    <= cnt_d;
      bm_a_q   <= bm_a_d;
      bm_d_q   <= bm_d_d;
      bm_wen_q <= bm_wen_d;
    end
  end

  assign sram_a_o    = sram_a_q;
  assign sram_wen_o  = 1'b1;
  assign bm_a_o      = bm_a_q;
  assign bm_d_o      = bm_d_q;
  assign bm_wen_o    = bm_wen_q;
  assign match_cnt_o = cnt_q;
  assign busy_o      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign finish_o    = (state_q == ST_DONE);

`ifdef CLE_PACKER_BBOX_EN
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CW-1:0] pix_x, pix_y;

  assign pix_x = pix_q[CW-1:0];
  assign pix_y = pix_q[AW-1:CW];

  // Empty box is min > max, so a run with no matches reads back 31/0.
  always_comb begin
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (start_ok) begin
      xmin_d = '1;
      xmax_d = '0;
      ymin_d = '1;
      ymax_d = '0;
    end else if (match) begin
      if (pix_x < xmin_q) xmin_d = pix_x;
      if (pix_x > xmax_q) xmax_d = pix_x;
      if (pix_y < ymin_q) ymin_d = pix_y;
      if (pix_y > ymax_q) ymax_d = pix_y;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xmin_q <= '1;
      xmax_q <= '0;
      ymin_q <= '1;
      ymax_q <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  assign bbox_xmin_o = xmin_q;
  assign bbox_xmax_o = xmax_q;
  assign bbox_ymin_o = ymin_q;
  assign bbox_ymax_o = ymax_q;
`else
  assign bbox_xmin_o = '0;
  assign bbox_xmax_o = '0;
  assign bbox_ymin_o = '0;
  assign bbox_ymax_o = '0;
`endif

endmodule

// File: tb/tb_cle_label_packer.sv
// Directed bench for cle_label_packer: SRAM model, bitmap capture monitor and
// hand-computed expectations for counts, bytes, latency and bounding boxes.
module tb_cle_label_packer;

`ifdef CLE_PACKER_BBOX_EN
  localparam bit BBOX_ON = 1'b1;
`else
  localparam bit BBOX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  label_sel = 8'd0;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        sram_wen;
  logic [6:0]  bm_a;
  logic [7:0]  bm_d;
  logic        bm_wen;
  logic [10:0] match_cnt;
  logic        busy, finish;
  logic [4:0]  bb_xmin, bb_xmax, bb_ymin, bb_ymax;

  cle_label_packer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .label_sel_i (label_sel),
    .sram_q_i    (sram_q),
    .sram_a_o    (sram_a),
    .sram_wen_o  (sram_wen),
    .bm_a_o      (bm_a),
    .bm_d_o      (bm_d),
    .bm_wen_o    (bm_wen),
    .match_cnt_o (match_cnt),
    .busy_o      (busy),
    .finish_o    (finish),
    .bbox_xmin_o (bb_xmin),
    .bbox_xmax_o (bb_xmax),
    .bbox_ymin_o (bb_ymin),
    .bbox_ymax_o (bb_ymax)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  logic       rom [0:1023];
  logic [7:0] cap [0:127];
  logic [7:0] orbm [0:127];
  int         wr_cnt = 0;
  int         order_err = 0;
  int         exp_addr = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always @(posedge clk) sram_q <= mem[sram_a];

  always @(negedge clk) begin
    if (bm_wen === 1'b0) begin
      cap[bm_a] = bm_d;
      if (int'(bm_a) != exp_addr) order_err++;
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [7:0] lbl, input int i);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = (mem[(i/4)*32 + (i%4)*8 + j] == lbl);
    return b;
  endfunction

  function automatic logic [7:0] rom_byte(input int i);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7-j] = rom[(i/4)*32 + (i%4)*8 + j];
    return b;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'd0;
      rom[i] = 1'b0;
    end
  endtask

  task automatic paint(input int x0, input int x1, input int y0, input int y1, input logic [7:0] lbl);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        mem[y*32 + x] = lbl;
        rom[y*32 + x] = 1'b1;
      end
  endtask

  task automatic start_run(input logic [7:0] lbl);
    wr_cnt = 0;
    order_err = 0;
    exp_addr = 0;
    for (int i = 0; i < 128; i++) cap[i] = 8'h5A;
    @(negedge clk);
    label_sel = lbl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = number of edges after the accepting edge when finish is first seen.
  task automatic wait_done(input int poke_at, output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_at) begin
        start = 1'b1;
        label_sel = ~label_sel;
      end else if (cyc == poke_at + 1) begin
        start = 1'b0;
      end
      if (finish === 1'b1) break;
    end
  endtask

  task automatic verify(input string name, input logic [7:0] lbl, input int exp_cnt,
                        input int cyc, input logic [19:0] exp_bb);
    logic [19:0] bb_exp;
    check({name, "_finish_cyc"}, cyc, 1026);
    check({name, "_wr_cnt"}, wr_cnt, 128);
    check({name, "_addr_order"}, order_err, 0);
    for (int i = 0; i < 128; i++)
      check($sformatf("%s_byte%0d", name, i), cap[i], model_byte(lbl, i));
    check({name, "_match_cnt"}, match_cnt, exp_cnt);
    bb_exp = BBOX_ON ? exp_bb : 20'd0;
    check({name, "_bbox"}, {bb_xmin, bb_xmax, bb_ymin, bb_ymax}, bb_exp);
  endtask

  localparam logic [39:0] RST_VEC = {10'd0, 1'b1, 7'd0, 8'd0, 1'b1, 11'd0, 1'b0, 1'b0};

  initial begin
    int cyc;
    int sum;
    int w;
    clear_mem();
    for (int i = 0; i < 128; i++) cap[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_vals", {sram_a, sram_wen, bm_a, bm_d, bm_wen, match_cnt, busy, finish}, RST_VEC);
    reset = 1'b0;

    // All-zero image, label 1: nothing matches.
    start_run(8'd1);
    check("t1_first_cycle", {busy, finish, sram_a}, {1'b1, 1'b0, 10'd0});
    wait_done(0, cyc);
    verify("t1", 8'd1, 0, cyc, {5'd31, 5'd0, 5'd31, 5'd0});
    check("t1_b0", cap[0], 8'h00);

    // Background extraction: every pixel matches.
    start_run(8'd0);
    wait_done(0, cyc);
    verify("t2", 8'd0, 1024, cyc, {5'd0, 5'd31, 5'd0, 5'd31});
    check("t2_b77", cap[77], 8'hFF);

    // Single pixel at x=9, y=2 lands in byte 9, bit 6.
    mem[2*32 + 9] = 8'd5;
    start_run(8'd5);
    wait_done(0, cyc);
    verify("t3", 8'd5, 1, cyc, {5'd9, 5'd9, 5'd2, 5'd2});
    check("t3_b9", cap[9], 8'h40);
    check("t3_b8", cap[8], 8'h00);

    // Three-object labeled image; OR of extractions must rebuild the binary image.
    clear_mem();
    paint(2, 5, 1, 3, 8'd1);
    paint(0, 31, 10, 10, 8'd2);
    paint(31, 31, 20, 29, 8'd3);
    for (int i = 0; i < 128; i++) orbm[i] = 8'h00;
    sum = 0;
    start_run(8'd1);
    wait_done(0, cyc);
    verify("t4_l1", 8'd1, 12, cyc, {5'd2, 5'd5, 5'd1, 5'd3});
    for (int i = 0; i < 128; i++) orbm[i] = orbm[i] | cap[i];
    sum += int'(match_cnt);
    start_run(8'd2);
    wait_done(0, cyc);
    verify("t4_l2", 8'd2, 32, cyc, {5'd0, 5'd31, 5'd10, 5'd10});
    for (int i = 0; i < 128; i++) orbm[i] = orbm[i] | cap[i];
    sum += int'(match_cnt);
    start_run(8'd3);
    wait_done(0, cyc);
    verify("t4_l3", 8'd3, 10, cyc, {5'd31, 5'd31, 5'd20, 5'd29});
    for (int i = 0; i < 128; i++) orbm[i] = orbm[i] | cap[i];
    sum += int'(match_cnt);
    for (int i = 0; i < 128; i++)
      check($sformatf("t4_or_byte%0d", i), orbm[i], rom_byte(i));
    check("t4_or_b4", orbm[4], 8'h3C);
    check("t4_or_b83", orbm[83], 8'h01);
    check("t4_popcount", sum, 54);

    // start and label_sel change mid-run must not disturb the run.
    start_run(8'd2);
    wait_done(500, cyc);
    verify("t5", 8'd2, 32, cyc, {5'd0, 5'd31, 5'd10, 5'd10});

    // Reset mid-run, then a clean rerun.
    start_run(8'd3);
    repeat (299) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_vals", {sram_a, sram_wen, bm_a, bm_d, bm_wen, match_cnt, busy, finish}, RST_VEC);
    reset = 1'b0;
    w = wr_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_writes", wr_cnt, w);
    check("t6_idle", {busy, finish}, 2'b00);
    start_run(8'd3);
    wait_done(0, cyc);
    verify("t6_rerun", 8'd3, 10, cyc, {5'd31, 5'd31, 5'd20, 5'd29});
    repeat (5) @(negedge clk);
    check("t6_cnt_hold", {finish, match_cnt}, {1'b1, 11'd10});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
